bridge_to_narrow: RTL and testbench

- Parametrised successor to the 32-bit-to-byte bridge serialiser.
- Splits one 32-bit bridge read or write into 32/MEM_WIDTH sequential narrow memory beats.
- Adds configurable beat width, endianness, independent read/write wait states, a one-deep pending-request slot and an overflow flag.
- Sits between the APF bridge decode and narrow (8/16-bit) on-chip or SDRAM-side memories in the loader path.

---
 rtl/bridge_pkg.sv | 28 ++
 rtl/bridge_req_slot.sv | 36 +++
 rtl/bridge_to_narrow.sv | 186 ++++++++++++++++++
 tb/tb_bridge_to_narrow.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared types and helpers for the 32-bit to narrow-memory bridge serialiser.
package bridge_pkg;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic        is_write;
  } req_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Beat k of a word, right-justified; beat 0 is the top slice when big_endian is set.
  function automatic logic [31:0] beat_slice(input logic [31:0] word, input logic [2:0] k,
                                             input int width, input bit big_endian);
    int          beats;
    int          pos;
    logic [31:0] mask;
    beats = 32 / width;
    pos   = big_endian ? (beats - 1 - int'(k)) : int'(k);
    mask  = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (word >> (pos * width)) & mask;
  endfunction

endpackage

// File: rtl/bridge_req_slot.sv
// One-entry pending request register; a push into a full slot is dropped and flagged.
module bridge_req_slot
  import bridge_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic i_push,
  input  req_t i_req,
  input  logic i_pop,
  output logic o_valid,
  output req_t o_req,
  output logic o_drop
);

  logic r_valid;
  req_t r_req;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= 1'b0;
      r_req   <= '0;
    end else if (i_push && !r_valid) begin
      r_valid <= 1'b1;
      r_req   <= i_req;
    end else if (i_pop) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= r_valid;
    end
  end

  assign o_valid = r_valid;
  assign o_req   = r_req;
  assign o_drop  = i_push & r_valid;

endmodule

// File: rtl/bridge_to_narrow.sv
// Splits each 32-bit bridge read/write into 32/MEM_WIDTH narrow memory beats with
// per-direction wait states, a one-deep pending slot and a sticky overflow flag.
module bridge_to_narrow
  import bridge_pkg::*;
#(
  parameter int MEM_WIDTH    = 8,
  parameter int READ_CYCLES  = 2,
  parameter int WRITE_CYCLES = 1,
  parameter int BIG_ENDIAN   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          bridge_addr,
  input  logic                 bridge_wr,
  input  logic                 bridge_rd,
  input  logic [31:0]          bridge_wr_data,
  output logic [31:0]          bridge_rd_data,
  output logic                 bridge_done,
  output logic                 busy,
  output logic                 overflow,
  output logic [31:0]          mem_addr,
  output logic                 mem_wr,
  output logic                 mem_rd,
  output logic [MEM_WIDTH-1:0] mem_wr_data,
  input  logic [MEM_WIDTH-1:0] mem_rd_data
);

  localparam int          NBEATS    = 32 / MEM_WIDTH;
  localparam logic [2:0]  BEAT_LAST = 3'(NBEATS - 1);
  localparam logic [15:0] RD_LAST   = 16'(READ_CYCLES - 1);
  localparam logic [15:0] WR_LAST   = 16'(WRITE_CYCLES - 1);
  localparam bit          BIG       = (BIG_ENDIAN != 0);

  if (!(MEM_WIDTH == 8 || MEM_WIDTH == 16 || MEM_WIDTH == 32)) begin : g_bad_width
    $error("bridge_to_narrow: MEM_WIDTH must be 8, 16 or 32");
  end
  if (READ_CYCLES < 1 || WRITE_CYCLES < 1) begin : g_bad_cycles
    $error("bridge_to_narrow: READ_CYCLES and WRITE_CYCLES must be >= 1");
  end

  state_e               r_state;
  req_t                 r_cur;
  logic [2:0]           r_beat;
  logic [15:0]          r_slot;
  logic [31:0]          r_mem_addr;
  logic                 r_mem_wr;
  logic                 r_mem_rd;
  logic [MEM_WIDTH-1:0] r_mem_wr_data;
  logic [31:0]          r_rd_cache;
  logic [31:0]          r_rd_data;
  logic                 r_done;
  logic                 r_overflow;

  logic        w_req_any;
  logic        w_collide;
  logic        w_accept_now;
  logic        w_push;
  logic        w_pop;
  logic        w_launch;
  logic        w_slot_valid;
  logic        w_slot_drop;
  req_t        w_new_req;
  req_t        w_launch_req;
  req_t        w_slot_req;
  logic [15:0] w_slot_last;
  logic [2:0]  w_pos;
  logic [31:0] w_rd_merged;

  bridge_req_slot u_slot (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_req   (w_new_req),
    .i_pop   (w_pop),
    .o_valid (w_slot_valid),
    .o_req   (w_slot_req),
    .o_drop  (w_slot_drop)
  );

  // DONE prefers the pending request; only an empty slot lets a fresh request launch there.
  always_comb begin
    w_req_any          = bridge_wr | bridge_rd;
    w_collide          = bridge_wr & bridge_rd;
    w_new_req.addr     = bridge_addr;
    w_new_req.data     = bridge_wr_data;
    w_new_req.is_write = bridge_wr;
    w_launch           = 1'b0;
    w_launch_req       = w_new_req;
    w_pop              = 1'b0;
    w_accept_now       = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept_now = 1'b1;
        w_launch     = w_req_any;
      end
      DONE: begin
        if (w_slot_valid) begin
          w_launch     = 1'b1;
          w_launch_req = w_slot_req;
          w_pop        = 1'b1;
        end else begin
          w_accept_now = 1'b1;
          w_launch     = w_req_any;
        end
      end
      default: begin
        w_accept_now = 1'b0;
      end
    endcase
    w_push      = w_req_any & ~w_accept_now;
    w_slot_last = r_cur.is_write ? WR_LAST : RD_LAST;
    w_pos       = BIG ? (BEAT_LAST - r_beat) : r_beat;
    w_rd_merged = r_rd_cache;
    w_rd_merged[int'(w_pos) * MEM_WIDTH +: MEM_WIDTH] = mem_rd_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= IDLE;
      r_cur         <= '0;
      r_beat        <= 3'd0;
      r_slot        <= 16'd0;
      r_mem_addr    <= 32'd0;
      r_mem_wr      <= 1'b0;
      r_mem_rd      <= 1'b0;
      r_mem_wr_data <= '0;
      r_rd_cache    <= 32'd0;
      r_rd_data     <= 32'd0;
      r_done        <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_mem_wr   <= 1'b0;
      r_mem_rd   <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= r_overflow | w_collide | w_slot_drop;
      case (r_state)
        RUN: begin
          if (r_slot == w_slot_last) begin
            if (!r_cur.is_write) r_rd_cache <= w_rd_merged;
            if (r_beat == BEAT_LAST) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              if (!r_cur.is_write) r_rd_data <= w_rd_merged;
            end else begin
              r_beat     <= r_beat + 3'd1;
              r_slot     <= 16'd0;
              r_mem_addr <= r_cur.addr + {29'd0, r_beat + 3'd1};
              r_mem_wr   <= r_cur.is_write;
              r_mem_rd   <= ~r_cur.is_write;
              if (r_cur.is_write)
                r_mem_wr_data <= MEM_WIDTH'(beat_slice(r_cur.data, r_beat + 3'd1, MEM_WIDTH, BIG));
            end
          end else begin
            r_slot <= r_slot + 16'd1;
          end
        end
        default: begin
          // IDLE and DONE both start a request with beat 0 on the following cycle
          if (w_launch) begin
            r_state    <= RUN;
            r_cur      <= w_launch_req;
            r_beat     <= 3'd0;
            r_slot     <= 16'd0;
            r_mem_addr <= w_launch_req.addr;
            r_mem_wr   <= w_launch_req.is_write;
            r_mem_rd   <= ~w_launch_req.is_write;
            if (w_launch_req.is_write)
              r_mem_wr_data <= MEM_WIDTH'(beat_slice(w_launch_req.data, 3'd0, MEM_WIDTH, BIG));
          end else begin
            r_state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bridge_rd_data = r_rd_data;
  assign bridge_done    = r_done;
  assign busy           = (r_state != IDLE) | w_slot_valid;
  assign overflow       = r_overflow;
  assign mem_addr       = r_mem_addr;
  assign mem_wr         = r_mem_wr;
  assign mem_rd         = r_mem_rd;
  assign mem_wr_data    = r_mem_wr_data;

endmodule

// File: tb/tb_bridge_to_narrow.sv
// Scoreboard bench for bridge_to_narrow: dut0 is 8-bit big-endian with 2-cycle reads,
// dut1 is 16-bit little-endian with single-cycle access and a combinational memory.
module tb_bridge_to_narrow;

  typedef struct {
    int          cyc;
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] b_addr[2];
  logic [31:0] b_wdata[2];
  logic        b_wr[2];
  logic        b_rd[2];
  logic [31:0] rd_data[2];
  logic        done[2];
  logic        busy_o[2];
  logic        ovf[2];
  logic [31:0] m_addr[2];
  logic        m_wr[2];
  logic        m_rd[2];
  logic [7:0]  m0_wdata;
  logic [7:0]  m0_rdata = 8'h00;
  logic [15:0] m1_wdata;
  logic [15:0] m1_rdata;

  int   edge_cnt = 0;
  int   base     = 0;
  int   n_vec    = 0;
  int   n_mis    = 0;
  exp_t beat_q[2][$];
  exp_t done_q[2][$];

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Registered memory model for dut0: returns addr[7:0] one cycle after mem_rd.
  always @(posedge clk) if (m_rd[0]) m0_rdata <= m_addr[0][7:0];

  assign m1_rdata = {8'hA5, m_addr[1][7:0]};

  bridge_to_narrow #(.MEM_WIDTH(8), .READ_CYCLES(2), .WRITE_CYCLES(1), .BIG_ENDIAN(1)) u_dut0 (
    .clk(clk), .reset(reset), .bridge_addr(b_addr[0]), .bridge_wr(b_wr[0]), .bridge_rd(b_rd[0]),
    .bridge_wr_data(b_wdata[0]), .bridge_rd_data(rd_data[0]), .bridge_done(done[0]),
    .busy(busy_o[0]), .overflow(ovf[0]), .mem_addr(m_addr[0]), .mem_wr(m_wr[0]),
    .mem_rd(m_rd[0]), .mem_wr_data(m0_wdata), .mem_rd_data(m0_rdata));

  bridge_to_narrow #(.MEM_WIDTH(16), .READ_CYCLES(1), .WRITE_CYCLES(1), .BIG_ENDIAN(0)) u_dut1 (
    .clk(clk), .reset(reset), .bridge_addr(b_addr[1]), .bridge_wr(b_wr[1]), .bridge_rd(b_rd[1]),
    .bridge_wr_data(b_wdata[1]), .bridge_rd_data(rd_data[1]), .bridge_done(done[1]),
    .busy(busy_o[1]), .overflow(ovf[1]), .mem_addr(m_addr[1]), .mem_wr(m_wr[1]),
    .mem_rd(m_rd[1]), .mem_wr_data(m1_wdata), .mem_rd_data(m1_rdata));

  task automatic check(input string nm, input int d, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s (dut%0d): got 0x%08h, want 0x%08h", nm, d, act, exp);
    end
  endtask

  task automatic exp_beat(input int d, input int rel, input bit wr, input logic [31:0] a,
                          input logic [31:0] dat);
    exp_t e;
    e.cyc = base + rel; e.is_wr = wr; e.addr = a; e.data = dat;
    beat_q[d].push_back(e);
  endtask

  task automatic exp_done(input int d, input int rel, input logic [31:0] rdv);
    exp_t e;
    e.cyc = base + rel; e.is_wr = 1'b0; e.addr = 32'd0; e.data = rdv;
    done_q[d].push_back(e);
  endtask

  // Present a one-cycle request; returns at the next falling edge.
  task automatic drive(input int d, input bit wr, input bit rd, input logic [31:0] a,
                       input logic [31:0] wd);
    b_wr[d] = wr; b_rd[d] = rd; b_addr[d] = a; b_wdata[d] = wd;
    @(negedge clk);
    b_wr[d] = 1'b0; b_rd[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every strobe and done pulse pops the oldest expectation of that kind.
  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] wd;
    for (int d = 0; d < 2; d++) begin
      wd = (d == 0) ? {24'd0, m0_wdata} : {16'd0, m1_wdata};
      while (beat_q[d].size() > 0 && beat_q[d][0].cyc < edge_cnt) begin
        e = beat_q[d].pop_front();
        check("missing beat strobe, cycle", d, 32'(edge_cnt), 32'(e.cyc));
      end
      while (done_q[d].size() > 0 && done_q[d][0].cyc < edge_cnt) begin
        e = done_q[d].pop_front();
        check("missing bridge_done, cycle", d, 32'(edge_cnt), 32'(e.cyc));
      end
      if (m_wr[d] || m_rd[d]) begin
        if (beat_q[d].size() == 0) begin
          check("unexpected strobe", d, 32'd1, 32'd0);
        end else begin
          e = beat_q[d].pop_front();
          check("beat cycle", d, 32'(edge_cnt), 32'(e.cyc));
          check("beat is write", d, {31'd0, m_wr[d]}, {31'd0, e.is_wr});
          check("beat both strobes", d, {31'd0, m_wr[d] & m_rd[d]}, 32'd0);
          check("beat addr", d, m_addr[d], e.addr);
          if (e.is_wr) check("beat wr data", d, wd, e.data);
        end
      end
      if (done[d]) begin
        if (done_q[d].size() == 0) begin
          check("unexpected bridge_done", d, 32'd1, 32'd0);
        end else begin
          e = done_q[d].pop_front();
          check("done cycle", d, 32'(edge_cnt), 32'(e.cyc));
          check("bridge_rd_data", d, rd_data[d], e.data);
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      b_wr[d] = 1'b0; b_rd[d] = 1'b0; b_addr[d] = 32'd0; b_wdata[d] = 32'd0;
    end
    idle(3);
    reset = 1'b0;
    idle(1);
    for (int d = 0; d < 2; d++) begin
      check("reset mem_wr/mem_rd/done", d, {29'd0, m_wr[d], m_rd[d], done[d]}, 32'd0);
      check("reset busy/overflow", d, {30'd0, busy_o[d], ovf[d]}, 32'd0);
      check("reset mem_addr", d, m_addr[d], 32'd0);
      check("reset rd_data", d, rd_data[d], 32'd0);
    end

    // dut0 write 0xDEADBEEF @0x100: big-endian bytes on cycles 1..4, done at 5
    base = edge_cnt;
    exp_beat(0, 1, 1'b1, 32'h100, 32'hDE);
    exp_beat(0, 2, 1'b1, 32'h101, 32'hAD);
    exp_beat(0, 3, 1'b1, 32'h102, 32'hBE);
    exp_beat(0, 4, 1'b1, 32'h103, 32'hEF);
    exp_done(0, 5, 32'h0000_0000);
    drive(0, 1'b1, 1'b0, 32'h100, 32'hDEAD_BEEF);
    idle(1);
    check("busy during write", 0, {31'd0, busy_o[0]}, 32'd1);
    idle(6);
    check("busy after write", 0, {31'd0, busy_o[0]}, 32'd0);

    // dut0 read @0x10: strobes 1,3,5,7; first byte lands in [31:24]
    base = edge_cnt;
    exp_beat(0, 1, 1'b0, 32'h10, 32'd0);
    exp_beat(0, 3, 1'b0, 32'h11, 32'd0);
    exp_beat(0, 5, 1'b0, 32'h12, 32'd0);
    exp_beat(0, 7, 1'b0, 32'h13, 32'd0);
    exp_done(0, 9, 32'h1011_1213);
    drive(0, 1'b0, 1'b1, 32'h10, 32'h0);
    idle(12);

    // dut0 back-to-back: write, read queued at cycle 2, third request dropped at cycle 3
    base = edge_cnt;
    exp_beat(0, 1, 1'b1, 32'h200, 32'hCA);
    exp_beat(0, 2, 1'b1, 32'h201, 32'hFE);
    exp_beat(0, 3, 1'b1, 32'h202, 32'hF0);
    exp_beat(0, 4, 1'b1, 32'h203, 32'h0D);
    exp_done(0, 5, 32'h1011_1213);
    exp_beat(0, 6, 1'b0, 32'h30, 32'd0);
    exp_beat(0, 8, 1'b0, 32'h31, 32'd0);
    exp_beat(0, 10, 1'b0, 32'h32, 32'd0);
    exp_beat(0, 12, 1'b0, 32'h33, 32'd0);
    exp_done(0, 14, 32'h3031_3233);
    drive(0, 1'b1, 1'b0, 32'h200, 32'hCAFE_F00D);
    idle(1);
    drive(0, 1'b0, 1'b1, 32'h30, 32'h0);
    check("busy with pending read", 0, {31'd0, busy_o[0]}, 32'd1);
    drive(0, 1'b1, 1'b0, 32'h300, 32'h5555_AAAA);
    idle(1);
    check("busy in done cycle", 0, {31'd0, busy_o[0]}, 32'd1);
    check("overflow after drop", 0, {31'd0, ovf[0]}, 32'd1);
    idle(14);

    // dut0 reset during cycle 2 of a write: strobes vanish at once, no done
    base = edge_cnt;
    exp_beat(0, 1, 1'b1, 32'h500, 32'hA1);
    exp_beat(0, 2, 1'b1, 32'h501, 32'hB2);
    drive(0, 1'b1, 1'b0, 32'h500, 32'hA1B2_C3D4);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("mem_wr under reset", 0, {31'd0, m_wr[0]}, 32'd0);
    check("busy under reset", 0, {31'd0, busy_o[0]}, 32'd0);
    check("overflow cleared by reset", 0, {31'd0, ovf[0]}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    idle(6);

    base = edge_cnt;
    exp_beat(0, 1, 1'b0, 32'h44, 32'd0);
    exp_beat(0, 3, 1'b0, 32'h45, 32'd0);
    exp_beat(0, 5, 1'b0, 32'h46, 32'd0);
    exp_beat(0, 7, 1'b0, 32'h47, 32'd0);
    exp_done(0, 9, 32'h4445_4647);
    drive(0, 1'b0, 1'b1, 32'h44, 32'h0);
    idle(12);

    // dut0 simultaneous write and read: write beats only, overflow set
    base = edge_cnt;
    exp_beat(0, 1, 1'b1, 32'h400, 32'h11);
    exp_beat(0, 2, 1'b1, 32'h401, 32'h22);
    exp_beat(0, 3, 1'b1, 32'h402, 32'h33);
    exp_beat(0, 4, 1'b1, 32'h403, 32'h44);
    exp_done(0, 5, 32'h4445_4647);
    drive(0, 1'b1, 1'b1, 32'h400, 32'h1122_3344);
    idle(8);
    check("overflow after collision", 0, {31'd0, ovf[0]}, 32'd1);

    // dut1 write 0x12345678 @0x40: little-endian halves, done at 3
    base = edge_cnt;
    exp_beat(1, 1, 1'b1, 32'h40, 32'h5678);
    exp_beat(1, 2, 1'b1, 32'h41, 32'h1234);
    exp_done(1, 3, 32'h0000_0000);
    drive(1, 1'b1, 1'b0, 32'h40, 32'h1234_5678);
    idle(5);

    // dut1 read @0x20 with single-cycle slots sampled in the strobe cycle
    base = edge_cnt;
    exp_beat(1, 1, 1'b0, 32'h20, 32'd0);
    exp_beat(1, 2, 1'b0, 32'h21, 32'd0);
    exp_done(1, 3, 32'hA521_A520);
    drive(1, 1'b0, 1'b1, 32'h20, 32'h0);
    idle(5);

    // dut1 write with a read queued behind it
    base = edge_cnt;
    exp_beat(1, 1, 1'b1, 32'h60, 32'hBEEF);
    exp_beat(1, 2, 1'b1, 32'h61, 32'h0000);
    exp_done(1, 3, 32'hA521_A520);
    exp_beat(1, 4, 1'b0, 32'h70, 32'd0);
    exp_beat(1, 5, 1'b0, 32'h71, 32'd0);
    exp_done(1, 6, 32'hA571_A570);
    drive(1, 1'b1, 1'b0, 32'h60, 32'h0000_BEEF);
    drive(1, 1'b0, 1'b1, 32'h70, 32'h0);
    idle(10);
    check("dut1 overflow stays clear", 1, {31'd0, ovf[1]}, 32'd0);
    check("dut1 busy at end", 1, {31'd0, busy_o[1]}, 32'd0);

    for (int d = 0; d < 2; d++) begin
      check("beat queue drained", d, 32'(beat_q[d].size()), 32'd0);
      check("done queue drained", d, 32'(done_q[d].size()), 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
